// File: rtl/muldiv_unit_if.sv
// Handshake and HI/LO bus between the EX stage and the iterative multiply/divide unit.
// The EX stage drives the master side and the unit implements the slave side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// Operands are made unsigned on entry, and the sign is restored in a single FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz_pend;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_b_abs;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic               w_signed;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_trial;
  logic [WIDTH-1:0]   w_rem_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;

  function automatic logic [WIDTH-1:0] abs_of(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return '0 - v;
    end else begin
      return v;
    end
  endfunction

  assign w_signed = ~bus.op[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == '0) begin
          w_next = S_FIX;
        end else begin
          w_next = S_CALC;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Multiply step adds b into the upper half when the low bit is set; divide step is restoring.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b_abs} : '0);
    w_rem_sh   = {r_rem, r_acc[WIDTH-1]};
    w_trial    = (w_rem_sh >= {1'b0, r_b_abs});
    w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b_abs;
    w_prod     = r_neg_q ? ('0 - r_acc) : r_acc;
    w_quo      = r_neg_q ? ('0 - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    w_rmd      = r_neg_r ? ('0 - r_rem) : r_rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_a_raw    <= '0;
      r_b_abs    <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_is_div   <= bus.op[1];
            r_a_raw    <= bus.a;
            r_b_abs    <= abs_of(bus.b, w_signed);
            r_acc      <= {{WIDTH{1'b0}}, abs_of(bus.a, w_signed)};
            r_rem      <= '0;
            r_neg_q    <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r    <= w_signed & bus.a[WIDTH-1];
            r_dz_pend  <= bus.op[1] && (bus.b == '0);
            r_cnt      <= CW'(WIDTH - 1);
            r_div_zero <= 1'b0;
          end else begin
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end
        S_CALC: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          if (r_is_div) begin
            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_trial};
            r_rem <= w_trial ? w_rem_diff : w_rem_sh[WIDTH-1:0];
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          // Divide by zero reports all-ones quotient and the untouched dividend.
          if (r_is_div && r_dz_pend) begin
            r_lo <= '1;
            r_hi <= r_a_raw;
          end else if (r_is_div) begin
            r_lo <= w_quo;
            r_hi <= w_rmd;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done     <= 1'b1;
          r_div_zero <= r_dz_pend;
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit that attaches to the EX stage of the five-stage pipeline and owns the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU one bit per cycle through a start/busy/done handshake. While `busy` is high, the pipeline must hold any instruction that touches HI/LO. It also services direct HI/LO writes (MTHI/MTLO) and exposes HI/LO continuously for MFHI/MFLO.

## Interface
- WIDTH, 32, operand and HI/LO width; any value ≥ 4.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- hi_we  in  1  write `wdata` to HI (MTHI).
- lo_we  in  1  write `wdata` to LO (MTLO).
- wdata  in  WIDTH  HI/LO direct-write data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- div_zero  out  1  set with `done` when a DIV/DIVU had b==0; cleared on the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- IDLE with start=1:
  - latch op;
  - latch |a| and |b| for signed ops, raw values for unsigned ops;
  - record the result sign (product: a^b sign; quotient: a^b sign; remainder: a sign);
  - load the iteration counter with WIDTH-1; clear div_zero; go to CALC.
- CALC: one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle.
  - Counter at 0: go to FIX.
  - Arithmetic is done in a 2*WIDTH accumulator plus a WIDTH+1 remainder path; no truncation before FIX.
- FIX: apply the sign correction (two's-complement negate), write HI/LO, set done, go to IDLE.
- Multiply result: {HI,LO} = full 2*WIDTH product.
  - MULT is signed×signed.
  - MULTU is unsigned×unsigned.
- Divide result: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
- Divide by zero (b==0, either divide op):
  - LO = all ones, HI = a (the original operand), div_zero=1;
  - timing is identical to a normal divide.
- Signed overflow (DIV of most-negative by -1): LO = most-negative, HI = 0, no flag.
- start while busy: ignored, no effect, no queueing.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0.
  - Ignored when busy or when start=1 in the same cycle (start wins).
  - Both may be asserted together; each then takes wdata.
- No other path modifies HI/LO. Operation results overwrite both HI and LO.

## Timing
- Reset values (async on rst_n low, immediate):
  - state IDLE, counter 0, hi 0, lo 0;
  - busy 0, done 0, div_zero 0.
- Start accepted at edge k:
  - busy=1 after edge k;
  - CALC steps on edges k+1 … k+WIDTH;
  - FIX at edge k+WIDTH+1 writes HI/LO.
- After edge k+WIDTH+1: busy=0 and done=1 for exactly one cycle; hi/lo/div_zero are valid in that cycle.
- Latency from start to result is WIDTH+1 cycles; busy is high for exactly WIDTH+1 cycles.
- Back-to-back: start may be asserted in the cycle where done=1. It is accepted at the next edge, so throughput is one operation per WIDTH+2 cycles.
- MTHI/MTLO: hi/lo reflect wdata after the writing edge, with one cycle of latency.
- div_zero holds until the next accepted start; done never holds longer than one cycle.
- rst_n asserted mid-operation: the operation is aborted, all outputs return to reset values, and no done pulse is produced.
- hi/lo are glitch-free register outputs; they change only at the FIX edge, at an MT edge, or on reset.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF (WIDTH=32) -> after 33 cycles done=1, HI=0xFFFFFFFE, LO=0x00000001; busy high exactly 33 cycles.
- MULT a=-3, b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=0x00000007, div_zero=1. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero cleared at the accepted start.
- start pulsed mid-CALC with different operands -> ignored; first result unchanged, single done pulse. hi_we=1 while busy -> HI unchanged.
- In IDLE: hi_we=1, wdata=0x1234 -> HI=0x1234 next cycle. start=1 with lo_we=1 in the same cycle -> LO not written; the operation result lands at done.
- rst_n low at cycle 10 of a MULTU -> hi=lo=0, busy=0, no done. A new DIVU 100/7 after release -> LO=14, HI=2. Repeat with WIDTH=8: MULTU 0xFF×0xFF -> HI=0xFE, LO=0x01 after 9 cycles.
